// File: rtl/mycpu_wb_stage_if.sv
// rtl/mycpu_wb_stage_if.sv - MEM-to-WB pipeline bus with valid/allowin handshake
interface mycpu_wb_stage_if;
  logic        ms_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [31:0] ms_alu_result;
  logic [31:0] ms_mem_rdata;
  logic [4:0]  ms_rt;
  logic [4:0]  ms_rd;
  logic        ms_C3;
  logic        ms_C4;
  logic        ms_C5;

  modport master (
    output ms_valid, ms_pc, ms_alu_result, ms_mem_rdata, ms_rt, ms_rd,
           ms_C3, ms_C4, ms_C5,
    input  ws_allowin
  );

  modport slave (
    input  ms_valid, ms_pc, ms_alu_result, ms_mem_rdata, ms_rt, ms_rd,
           ms_C3, ms_C4, ms_C5,
    output ws_allowin
  );
endinterface

// File: rtl/mycpu_wb_stage.sv
// rtl/mycpu_wb_stage.sv - write-back stage: pipeline register, register-file write port, trace port
module mycpu_wb_stage #(
  parameter int COUNT_W       = 32,
  parameter int ZERO_SUPPRESS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  mycpu_wb_stage_if.slave      ms,
  input  logic                 trace_hold,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [4:0]           ws_dest,
  output logic [31:0]          debug_wb_pc,
  output logic [3:0]           debug_wb_rf_wen,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [31:0]          debug_wb_rf_wdata,
  output logic [COUNT_W-1:0]   retire_count
);

  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [31:0] ws_wdata;
  logic [4:0]  ws_waddr;
  logic        ws_regwrite;
  logic        ws_ready_go;
  logic        ws_accept;
  logic        ws_leave;
  logic        waddr_ok;

  assign ws_ready_go   = ~trace_hold;
  assign ms.ws_allowin = ~ws_valid | ws_ready_go;
  assign ws_accept     = ms.ms_valid & ms.ws_allowin;
  assign ws_leave      = ws_valid & ws_ready_go;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_valid <= 1'b0;
    end else if (ms.ws_allowin) begin
      ws_valid <= ms.ms_valid;
    end
  end

  // Entry registers load only on a real accept so a held entry stays bit-stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ws_pc       <= 32'd0;
      ws_wdata    <= 32'd0;
      ws_waddr    <= 5'd0;
      ws_regwrite <= 1'b0;
    end else if (ws_accept) begin
      ws_pc       <= ms.ms_pc;
      ws_waddr    <= ms.ms_C3 ? ms.ms_rt : ms.ms_rd;
      ws_wdata    <= ms.ms_C4 ? ms.ms_mem_rdata : ms.ms_alu_result;
      ws_regwrite <= ms.ms_C5;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_count <= '0;
    end else if (ws_leave) begin
      retire_count <= retire_count + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Register 0 is hard-wired zero; suppressing its writes keeps the trace clean.
  assign waddr_ok = (ws_waddr != 5'd0) || (ZERO_SUPPRESS == 0);
  assign rf_wen   = ws_leave & ws_regwrite & waddr_ok;
  assign rf_waddr = ws_waddr;
  assign rf_wdata = ws_wdata;
  assign ws_dest  = (ws_valid & ws_regwrite) ? ws_waddr : 5'd0;

  assign debug_wb_pc       = ws_pc;
  assign debug_wb_rf_wen   = {4{rf_wen}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_mycpu_wb_stage.sv
// tb/tb_mycpu_wb_stage.sv - scoreboard bench for mycpu_wb_stage with directed vectors
module tb_mycpu_wb_stage;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          trace_hold;
  logic          rf_wen;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [4:0]    ws_dest;
  logic [31:0]   debug_wb_pc;
  logic [3:0]    debug_wb_rf_wen;
  logic [4:0]    debug_wb_rf_wnum;
  logic [31:0]   debug_wb_rf_wdata;
  logic [CW-1:0] retire_count;

  mycpu_wb_stage_if wb_if ();

  mycpu_wb_stage #(.COUNT_W(CW), .ZERO_SUPPRESS(1)) dut (
    .clk               (clk),
    .rst               (rst),
    .ms                (wb_if.slave),
    .trace_hold        (trace_hold),
    .rf_wen            (rf_wen),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_dest           (ws_dest),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .retire_count      (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_retired = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every visible write must match the oldest outstanding writer.
  always @(negedge clk) begin
    if (rst && debug_wb_rf_wen != 4'h0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write_pc", debug_wb_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_pc",       debug_wb_pc, e.pc);
        chk("wr_waddr",    {27'd0, rf_waddr}, {27'd0, e.waddr});
        chk("wr_wdata",    rf_wdata, e.wdata);
        chk("wr_dbg_wen",  {28'd0, debug_wb_rf_wen}, 32'hF);
        chk("wr_dbg_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, e.waddr});
        chk("wr_dbg_data", debug_wb_rf_wdata, e.wdata);
        chk("wr_not_held", {31'd0, trace_hold}, 32'd0);
      end
    end
  end

  task automatic present(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mrd,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic c3, input logic c4, input logic c5, input bit push);
    exp_t e;
    wb_if.ms_pc         = pc;
    wb_if.ms_alu_result = alu;
    wb_if.ms_mem_rdata  = mrd;
    wb_if.ms_rt         = rt;
    wb_if.ms_rd         = rd;
    wb_if.ms_C3         = c3;
    wb_if.ms_C4         = c4;
    wb_if.ms_C5         = c5;
    wb_if.ms_valid      = 1'b1;
    e.pc    = pc;
    e.waddr = c3 ? rt : rd;
    e.wdata = c4 ? mrd : alu;
    if (push && c5 && e.waddr != 5'd0) exp_q.push_back(e);
    if (push) exp_retired++;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mrd,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic c3, input logic c4, input logic c5, input bit push);
    present(pc, alu, mrd, rt, rd, c3, c4, c5, push);
    @(posedge clk);
    #1 wb_if.ms_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    trace_hold = 1'b0;
    wb_if.ms_valid = 1'b0;
    wb_if.ms_pc = '0; wb_if.ms_alu_result = '0; wb_if.ms_mem_rdata = '0;
    wb_if.ms_rt = '0; wb_if.ms_rd = '0;
    wb_if.ms_C3 = 1'b0; wb_if.ms_C4 = 1'b0; wb_if.ms_C5 = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_allowin", {31'd0, wb_if.ws_allowin}, 32'd1);
    chk("rst_wen",     {31'd0, rf_wen}, 32'd0);
    chk("rst_waddr",   {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata",   rf_wdata, 32'd0);
    chk("rst_dest",    {27'd0, ws_dest}, 32'd0);
    chk("rst_dbg_pc",  debug_wb_pc, 32'd0);
    chk("rst_count",   {28'd0, retire_count}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // addu rd=8
    issue(32'hBFC0_0000, 32'h0000_1234, 32'h0, 5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("addu_dest",  {27'd0, ws_dest}, 32'd8);
    chk("addu_wen",   {31'd0, rf_wen}, 32'd1);
    chk("addu_cnt0",  {28'd0, retire_count}, 32'd0);
    @(negedge clk);
    chk("addu_cnt1",  {28'd0, retire_count}, 32'd1);
    chk("idle_dest",  {27'd0, ws_dest}, 32'd0);

    // lw rt=9
    issue(32'hBFC0_0004, 32'h0000_0100, 32'hDEAD_BEEF, 5'd9, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("lw_dest", {27'd0, ws_dest}, 32'd9);
    @(negedge clk);
    chk("lw_cnt", {28'd0, retire_count}, 32'd2);

    // addiu to r0: suppressed write, still retires
    issue(32'hBFC0_0008, 32'h0000_0055, 32'h0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("r0_wen",     {31'd0, rf_wen}, 32'd0);
    chk("r0_dbg_wen", {28'd0, debug_wb_rf_wen}, 32'd0);
    @(negedge clk);
    chk("r0_cnt", {28'd0, retire_count}, 32'd3);

    // sw: no register write
    issue(32'hBFC0_000C, 32'h0000_0200, 32'h0, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("sw_wen",  {31'd0, rf_wen}, 32'd0);
    chk("sw_dest", {27'd0, ws_dest}, 32'd0);
    @(negedge clk);
    chk("sw_cnt", {28'd0, retire_count}, 32'd4);

    // Two back-to-back writers with a 3-cycle hold on the first
    issue(32'hBFC0_0010, 32'hA5A5_0001, 32'h0, 5'd1, 5'd10, 1'b0, 1'b0, 1'b1, 1'b1);
    trace_hold = 1'b1;
    present(32'hBFC0_0014, 32'h0, 32'h5A5A_0002, 5'd12, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_allowin", {31'd0, wb_if.ws_allowin}, 32'd0);
      chk("hold_wen",     {31'd0, rf_wen}, 32'd0);
      chk("hold_waddr",   {27'd0, rf_waddr}, 32'd10);
      chk("hold_wdata",   rf_wdata, 32'hA5A5_0001);
      chk("hold_dest",    {27'd0, ws_dest}, 32'd10);
      @(posedge clk);
    end
    #1 trace_hold = 1'b0;
    @(posedge clk);
    #1 wb_if.ms_valid = 1'b0;
    @(negedge clk);
    chk("b2b_dest2", {27'd0, ws_dest}, 32'd12);
    @(negedge clk);
    chk("b2b_cnt", {28'd0, retire_count}, 32'd6);

    // Asynchronous reset while an entry is held: it must be dropped
    issue(32'hBFC0_0018, 32'h1111_2222, 32'h0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0);
    trace_hold = 1'b1;
    @(negedge clk);
    chk("pre_rst_dest", {27'd0, ws_dest}, 32'd11);
    #2 rst = 1'b0;
    #1;
    chk("arst_allowin", {31'd0, wb_if.ws_allowin}, 32'd1);
    chk("arst_waddr",   {27'd0, rf_waddr}, 32'd0);
    chk("arst_wdata",   rf_wdata, 32'd0);
    chk("arst_dest",    {27'd0, ws_dest}, 32'd0);
    chk("arst_dbg_pc",  debug_wb_pc, 32'd0);
    chk("arst_count",   {28'd0, retire_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    trace_hold = 1'b0;
    exp_retired = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_allowin", {31'd0, wb_if.ws_allowin}, 32'd1);
    chk("post_rst_count",   {28'd0, retire_count}, 32'd0);

    // 17 continuous writers: counter wraps 15 -> 0 -> 1
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      present(32'hBFC0_1000 + 32'(i * 4), 32'h0000_1000 + 32'(i), 32'h0,
              5'd0, 5'(i + 1), 1'b0, 1'b0, 1'b1, 1'b1);
      @(posedge clk); #1;
      if (i > 0) chk("wrap_cnt", {28'd0, retire_count}, 32'(i % 16));
    end
    wb_if.ms_valid = 1'b0;
    @(posedge clk); #1;
    chk("wrap_cnt_final", {28'd0, retire_count}, 32'(exp_retired % 16));

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mycpu_wb_stage.md
Name: mycpu_wb_stage

Overview:
- Write-back stage of the myCPU pipeline; the write-side partner of the decode stage's register-file read port.
- Holds one retiring instruction in a valid/allowin pipeline register and selects the write data and destination register.
- Drives the register-file write port (wen/waddr/wdata) consumed by the decode stage, plus the debug trace port used by the verification environment.
- Publishes its destination register for hazard detection and counts retired instructions.

Parameters:
COUNT_W, 32, width of the retired-instruction counter (wraps modulo 2^COUNT_W)
ZERO_SUPPRESS, 1, when 1, writes to register 0 never assert rf_wen

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
ms_valid  in  1  MEM stage presents a valid instruction
ws_allowin  out  1  WB can accept an instruction this cycle
ms_pc  in  32  PC of the presented instruction
ms_alu_result  in  32  ALU result
ms_mem_rdata  in  32  load data
ms_rt  in  5  rt field
ms_rd  in  5  rd field
ms_C3  in  1  destination is rt (else rd)
ms_C4  in  1  load: write data is ms_mem_rdata (else ms_alu_result)
ms_C5  in  1  instruction writes a register
trace_hold  in  1  verification backpressure; holds the WB entry
rf_wen  out  1  register-file write enable
rf_waddr  out  5  register-file write address
rf_wdata  out  32  register-file write data
ws_dest  out  5  destination of a valid writing entry, else 0 (hazard check)
debug_wb_pc  out  32  PC of the entry in WB
debug_wb_rf_wen  out  4  byte write enables, {4{rf_wen}}
debug_wb_rf_wnum  out  5  equals rf_waddr
debug_wb_rf_wdata  out  32  equals rf_wdata
retire_count  out  COUNT_W  number of instructions retired

Behaviour:
- State consists of ws_valid, ws_pc, ws_wdata, ws_waddr, ws_regwrite, and retire_count.
- Reset (rst=0, asynchronous): ws_valid=0 and all registers are cleared. Outputs during reset:
  - ws_allowin=1
  - rf_wen=0, rf_waddr=0, rf_wdata=0
  - ws_dest=0, debug_* = 0
  - retire_count=0
- An entry caught in WB when reset asserts is dropped and never written.
- Handshake:
  - ws_ready_go = ~trace_hold.
  - ws_allowin = ~ws_valid | ws_ready_go.
  - Accept on a rising edge when ms_valid & ws_allowin.
- Capture on accept:
  - ws_pc ← ms_pc.
  - ws_waddr ← ms_C3 ? ms_rt : ms_rd.
  - ws_wdata ← ms_C4 ? ms_mem_rdata : ms_alu_result.
  - ws_regwrite ← ms_C5.
- ws_valid next state:
  - If ws_allowin, ws_valid ← ms_valid.
  - Otherwise ws_valid holds and all entry registers hold.
- Write port (combinational from registered state):
  - rf_wen = ws_valid & ws_ready_go & ws_regwrite & (ws_waddr!=0 | ZERO_SUPPRESS==0).
  - rf_waddr = ws_waddr; rf_wdata = ws_wdata.
  - The register file commits on the edge that ends the WB cycle.
- Latency: an instruction accepted at edge N drives rf_wen during cycle N+1 and commits at edge N+1 if trace_hold=0.
- Exactly-once write: rf_wen is only high in the cycle in which the entry leaves. A held entry keeps rf_wen=0 and presents identical data until released.
- Back-to-back: with trace_hold=0 the stage accepts a new instruction every cycle; throughput is 1 per cycle.
- Simultaneous leave and accept in one cycle: the old entry writes and the new entry is captured on the same edge.
- ws_dest = (ws_valid & ws_regwrite) ? ws_waddr : 0. It stays valid while the entry is held.
- retire_count increments by 1 on each edge where ws_valid & ws_ready_go. It wraps from 2^COUNT_W−1 to 0. Non-writing instructions (sw, branches) also count.
- Debug port:
  - debug_wb_pc = ws_pc.
  - debug_wb_rf_wen = {4{rf_wen}}.
  - debug_wb_rf_wnum = rf_waddr; debug_wb_rf_wdata = rf_wdata.
  - Checkers sample only when debug_wb_rf_wen != 0.

Test Plan:
- addu to rd=8, alu=0x0000_1234, C3=0, C4=0, C5=1, accept at edge N → cycle N+1: rf_wen=1, waddr=8, wdata=0x1234, debug_wb_rf_wen=4'hF, retire_count=1 after edge N+1.
- lw to rt=9, C3=1, C4=1, mem_rdata=0xDEAD_BEEF, alu=0x100 → waddr=9, wdata=0xDEADBEEF; ws_dest=9 while the entry is in WB.
- addiu to rt=0 with ZERO_SUPPRESS=1 → rf_wen=0, debug_wb_rf_wen=0, retire_count still increments; sw (C5=0) → rf_wen=0, ws_dest=0.
- Two back-to-back writers, trace_hold=1 for 3 cycles after the first is accepted → ws_allowin=0, rf_wen=0 and data stable for 3 cycles. The first instruction writes once after release, the second follows the next cycle, and retire_count=2.
- rst pulsed low mid-cycle while a valid entry is held → outputs go to 0 immediately (asynchronously); after release ws_allowin=1, no write of the dropped entry, retire_count=0.
- COUNT_W=4, retire 17 instructions continuously → retire_count sequence 1..15, 0, 1.
